// File: rtl/pad_cfg_pkg.sv
// rtl/pad_cfg_pkg.sv - shared constants, state enum and helpers for the pad configuration SPI block
package pad_cfg_pkg;

  localparam int CFG_OVR_EN  = 0;
  localparam int CFG_OVR_OE  = 1;
  localparam int CFG_OVR_OUT = 2;
  localparam int CFG_IE      = 3;
  localparam int CFG_CS      = 4;
  localparam int CFG_SL      = 5;
  localparam int CFG_PU      = 6;
  localparam int CFG_PD      = 7;

  localparam int IN_PU = 0;
  localparam int IN_PD = 1;

  localparam logic [6:0] ADDR_INPUT_BASE = 7'h40;
  localparam logic [6:0] ADDR_LOCK       = 7'h7E;
  localparam logic [6:0] ADDR_ID         = 7'h7F;

  localparam logic [7:0] BIDIR_CFG_RST = 8'h08;
  localparam logic [7:0] INPUT_CFG_RST = 8'h00;
  localparam logic [7:0] LOCK_KEY      = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_HOLD
  } spi_state_e;

  // Pull-up wins when both pulls are requested, so a pad is never fought by both.
  function automatic logic [7:0] resolve_bidir_pulls(input logic [7:0] d);
    logic [7:0] r;
    r = d;
    r[CFG_PD] = d[CFG_PD] & ~d[CFG_PU];
    return r;
  endfunction

endpackage

// File: rtl/pad_cfg_sync.sv
// rtl/pad_cfg_sync.sv - parameterised-width two-flop synchroniser with async active-low reset
module pad_cfg_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pad_cfg_spi.sv
// rtl/pad_cfg_spi.sv - SPI-programmed pad control registers; lock register built when PAD_CFG_LOCK_EN is defined
module pad_cfg_spi
  import pad_cfg_pkg::*;
#(
  parameter int         NUM_INPUT_PADS = 13,
  parameter int         NUM_BIDIR_PADS = 41,
  parameter logic [7:0] ID_VALUE       = 8'hB7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_sclk,
  input  logic                      spi_csn,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      spi_miso_oe,
  input  logic [NUM_BIDIR_PADS-1:0] core_out,
  input  logic [NUM_BIDIR_PADS-1:0] core_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd,
  output logic                      cfg_wr
);

  localparam int BW = (NUM_BIDIR_PADS > 1) ? $clog2(NUM_BIDIR_PADS) : 1;
  localparam int IW = (NUM_INPUT_PADS > 1) ? $clog2(NUM_INPUT_PADS) : 1;
  localparam logic [6:0] BIDIR_LIMIT = 7'(NUM_BIDIR_PADS);
  localparam logic [6:0] INPUT_LIMIT = ADDR_INPUT_BASE + 7'(NUM_INPUT_PADS);

  logic sclk_s, csn_s, mosi_s, sclk_d;
  logic sclk_rise, sclk_fall;

  spi_state_e state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] tx_sh;
  logic [6:0] addr_q;
  logic       wr_q;
  logic       locked;

  logic [7:0] bidir_cfg [NUM_BIDIR_PADS];
  logic [1:0] input_cfg [NUM_INPUT_PADS];

  logic [6:0] cmd_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_byte;
  logic       wr_is_bidir, wr_is_input;

  pad_cfg_sync #(
    .WIDTH  (3),
    .RST_VAL(3'b010)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({spi_sclk, spi_csn, spi_mosi}),
    .q    ({sclk_s, csn_s, mosi_s})
  );

  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign spi_miso_oe = ~csn_s;

  // Address and data are complete on the rise that delivers their last bit.
  assign cmd_addr    = {rx_sh[5:0], mosi_s};
  assign wr_data     = {rx_sh, mosi_s};
  assign wr_is_bidir = (addr_q < BIDIR_LIMIT);
  assign wr_is_input = (addr_q >= ADDR_INPUT_BASE) && (addr_q < INPUT_LIMIT);

`ifdef PAD_CFG_LOCK_EN
  logic lock;
  assign locked = lock;
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    rd_byte = 8'h00;
    if (cmd_addr < BIDIR_LIMIT)
      rd_byte = bidir_cfg[cmd_addr[BW-1:0]];
    else if ((cmd_addr >= ADDR_INPUT_BASE) && (cmd_addr < INPUT_LIMIT))
      rd_byte = {6'b0, input_cfg[cmd_addr[IW-1:0]]};
    else if (cmd_addr == ADDR_ID)
      rd_byte = ID_VALUE;
`ifdef PAD_CFG_LOCK_EN
    else if (cmd_addr == ADDR_LOCK)
      rd_byte = {7'b0, lock};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      rx_sh    <= 7'd0;
      tx_sh    <= 8'd0;
      addr_q   <= 7'd0;
      wr_q     <= 1'b0;
      sclk_d   <= 1'b0;
      spi_miso <= 1'b0;
      cfg_wr   <= 1'b0;
      for (int i = 0; i < NUM_BIDIR_PADS; i++) bidir_cfg[i] <= BIDIR_CFG_RST;
      for (int i = 0; i < NUM_INPUT_PADS; i++) input_cfg[i] <= INPUT_CFG_RST[1:0];
`ifdef PAD_CFG_LOCK_EN
      lock     <= 1'b0;
`endif
    end else begin
      sclk_d   <= sclk_s;
      cfg_wr   <= 1'b0;
      spi_miso <= (state == ST_DATA && !wr_q) ? tx_sh[7] : 1'b0;
      if (csn_s) begin
        state   <= ST_IDLE;
        bit_cnt <= 3'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_CMD;
            bit_cnt <= 3'd0;
          end
          ST_CMD: begin
            if (sclk_rise) begin
              rx_sh   <= {rx_sh[5:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                wr_q   <= rx_sh[6];
                addr_q <= cmd_addr;
                tx_sh  <= rd_byte;
                state  <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              rx_sh   <= {rx_sh[5:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= ST_HOLD;
                if (wr_q && !locked) begin
                  if (wr_is_bidir) begin
                    bidir_cfg[addr_q[BW-1:0]] <= resolve_bidir_pulls(wr_data);
                    cfg_wr <= 1'b1;
                  end else if (wr_is_input) begin
                    input_cfg[addr_q[IW-1:0]] <= {wr_data[IN_PD] & ~wr_data[IN_PU], wr_data[IN_PU]};
                    cfg_wr <= 1'b1;
                  end
`ifdef PAD_CFG_LOCK_EN
                  else if (addr_q == ADDR_LOCK && wr_data == LOCK_KEY) begin
                    lock   <= 1'b1;
                    cfg_wr <= 1'b1;
                  end
`endif
                end
              end
            end else if (sclk_fall && bit_cnt != 3'd0) begin
              // The fall right after the command byte is skipped so the MSB is held for the first data rise.
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_BIDIR_PADS; i++) begin : g_bidir
    assign bidir_oe[i]  = bidir_cfg[i][CFG_OVR_EN] ? bidir_cfg[i][CFG_OVR_OE]  : core_oe[i];
    assign bidir_out[i] = bidir_cfg[i][CFG_OVR_EN] ? bidir_cfg[i][CFG_OVR_OUT] : core_out[i];
    assign bidir_ie[i]  = bidir_cfg[i][CFG_IE];
    assign bidir_cs[i]  = bidir_cfg[i][CFG_CS];
    assign bidir_sl[i]  = bidir_cfg[i][CFG_SL];
    assign bidir_pu[i]  = bidir_cfg[i][CFG_PU];
    assign bidir_pd[i]  = bidir_cfg[i][CFG_PD];
  end

  for (genvar i = 0; i < NUM_INPUT_PADS; i++) begin : g_input
    assign input_pu[i] = input_cfg[i][IN_PU];
    assign input_pd[i] = input_cfg[i][IN_PD];
  end

endmodule

// File: tb/tb_pad_cfg_spi.sv
// tb/tb_pad_cfg_spi.sv - directed self-checking bench for pad_cfg_spi
module tb_pad_cfg_spi;

  localparam int NI   = 13;
  localparam int NB   = 41;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0, csn = 1'b1, mosi = 1'b0;
  logic spi_miso, spi_miso_oe, cfg_wr;
  logic [NB-1:0] core_out = 41'h155_5555_5555;
  logic [NB-1:0] core_oe  = 41'h0AA_AAAA_AAAA;
  logic [NB-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic [NI-1:0] input_pu, input_pd;

  int tests = 0;
  int fails = 0;
  int wr_cycles = 0;
  logic wr_d = 1'b0;
  logic oe_mid = 1'b0;
  logic [NB-1:0] snap_oe = '0, snap_out = '0;

  pad_cfg_spi #(
    .NUM_INPUT_PADS(NI),
    .NUM_BIDIR_PADS(NB),
    .ID_VALUE      (8'hB7)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sclk(sclk), .spi_csn(csn), .spi_mosi(mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .core_out(core_out), .core_oe(core_oe),
    .bidir_out(bidir_out), .bidir_oe(bidir_oe), .bidir_cs(bidir_cs), .bidir_sl(bidir_sl),
    .bidir_ie(bidir_ie), .bidir_pu(bidir_pu), .bidir_pd(bidir_pd),
    .input_pu(input_pu), .input_pd(input_pd),
    .cfg_wr(cfg_wr)
  );

  always #5 clk = ~clk;

  // Counts every high cycle of cfg_wr and snapshots the pads one cycle after it.
  always @(posedge clk) begin
    if (wr_d) begin
      snap_oe  = bidir_oe;
      snap_out = bidir_out;
    end
    wr_d = cfg_wr;
    if (cfg_wr) wr_cycles++;
  end

  task automatic spi_frame(input logic [15:0] w, input int nbits, input int rst_at, output logic [7:0] rd);
    logic [15:0] sh;
    sh = '0;
    csn = 1'b0;
    #(HALF);
    for (int k = 0; k < nbits; k++) begin
      mosi = (k < 16) ? w[15-k] : 1'b1;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
      end
      #(HALF);
      sh = {sh[14:0], spi_miso};
      if (k == 4) oe_mid = spi_miso_oe;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
    end
    #(HALF);
    csn = 1'b1;
    #(2*HALF);
    rd = sh[7:0];
  endtask

  task automatic spi_write(input logic [15:0] w);
    logic [7:0] rd;
    spi_frame(w, 16, -1, rd);
  endtask

  task automatic spi_read(input logic [6:0] a, output logic [7:0] rd);
    spi_frame({1'b0, a, 8'h00}, 16, -1, rd);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #40;
    rst_n = 1'b1;
    #40;
    tests++; if (bidir_ie !== {NB{1'b1}}) begin fails++; $display("FAIL reset_ie got %h want all ones", bidir_ie); end
    tests++; if ((bidir_cs | bidir_sl | bidir_pu | bidir_pd) !== '0) begin fails++; $display("FAIL reset_ctrl got cs %h sl %h pu %h pd %h want 0", bidir_cs, bidir_sl, bidir_pu, bidir_pd); end
    tests++; if ((input_pu | input_pd) !== '0) begin fails++; $display("FAIL reset_input got pu %h pd %h want 0", input_pu, input_pd); end
    tests++; if (bidir_oe !== 41'h0AA_AAAA_AAAA || bidir_out !== 41'h155_5555_5555) begin fails++; $display("FAIL reset_follow got oe %h out %h", bidir_oe, bidir_out); end
    core_oe = 41'h1F0_0F0F_0F0F;
    #10;
    tests++; if (bidir_oe !== 41'h1F0_0F0F_0F0F) begin fails++; $display("FAIL reset_follow2 got %h want 1f00f0f0f0f", bidir_oe); end
    tests++; if ({spi_miso_oe, spi_miso, cfg_wr} !== 3'b000) begin fails++; $display("FAIL reset_spi got oe %b miso %b wr %b want 000", spi_miso_oe, spi_miso, cfg_wr); end
  endtask

  task automatic test_write_override;
    int w0;
    core_oe[5]  = 1'b0;
    core_out[5] = 1'b0;
    w0 = wr_cycles;
    spi_write(16'h8507);
    tests++; if (wr_cycles !== w0 + 1) begin fails++; $display("FAIL ovr_cfg_wr got %0d cycles want 1", wr_cycles - w0); end
    tests++; if (snap_oe[5] !== 1'b1 || snap_out[5] !== 1'b1) begin fails++; $display("FAIL ovr_next_cycle got oe %b out %b want 1 1", snap_oe[5], snap_out[5]); end
    tests++; if (bidir_oe[5] !== 1'b1 || bidir_out[5] !== 1'b1) begin fails++; $display("FAIL ovr_pad got oe %b out %b want 1 1", bidir_oe[5], bidir_out[5]); end
    tests++; if (bidir_oe[6] !== core_oe[6] || bidir_ie[5] !== 1'b0) begin fails++; $display("FAIL ovr_other got oe6 %b ie5 %b want %b 0", bidir_oe[6], bidir_ie[5], core_oe[6]); end
  endtask

  task automatic test_read;
    logic [7:0] rd;
    spi_read(7'h7F, rd);
    tests++; if (rd !== 8'hB7) begin fails++; $display("FAIL read_id got %h want b7", rd); end
    tests++; if (oe_mid !== 1'b1) begin fails++; $display("FAIL miso_oe got %b want 1", oe_mid); end
    spi_read(7'h05, rd);
    tests++; if (rd !== 8'h07) begin fails++; $display("FAIL read_05 got %h want 07", rd); end
    spi_read(7'h03, rd);
    tests++; if (rd !== 8'h08) begin fails++; $display("FAIL read_03 got %h want 08", rd); end
    spi_read(7'h30, rd);
    tests++; if (rd !== 8'h00) begin fails++; $display("FAIL read_unmapped got %h want 00", rd); end
    tests++; if (spi_miso_oe !== 1'b0) begin fails++; $display("FAIL miso_oe_idle got %b want 0", spi_miso_oe); end
  endtask

  task automatic test_input_pull;
    logic [7:0] rd;
    spi_write(16'hC003);
    tests++; if (input_pu[0] !== 1'b1 || input_pd[0] !== 1'b0) begin fails++; $display("FAIL in0_pull got pu %b pd %b want 1 0", input_pu[0], input_pd[0]); end
    spi_read(7'h40, rd);
    tests++; if (rd !== 8'h01) begin fails++; $display("FAIL in0_read got %h want 01", rd); end
    spi_write(16'hCCFE);
    tests++; if (input_pd[12] !== 1'b1 || input_pu[12] !== 1'b0) begin fails++; $display("FAIL in12_pull got pu %b pd %b want 0 1", input_pu[12], input_pd[12]); end
    spi_read(7'h4C, rd);
    tests++; if (rd !== 8'h02) begin fails++; $display("FAIL in12_read got %h want 02", rd); end
  endtask

  task automatic test_partial;
    logic [7:0] rd;
    int w0;
    w0 = wr_cycles;
    spi_frame(16'h83C0, 12, -1, rd);
    tests++; if (wr_cycles !== w0) begin fails++; $display("FAIL partial_wr got %0d cycles want 0", wr_cycles - w0); end
    tests++; if (bidir_pu[3] !== 1'b0 || bidir_pd[3] !== 1'b0) begin fails++; $display("FAIL partial_reg got pu %b pd %b want 0 0", bidir_pu[3], bidir_pd[3]); end
    w0 = wr_cycles;
    spi_frame(16'h8340, 20, -1, rd);
    tests++; if (wr_cycles !== w0 + 1) begin fails++; $display("FAIL long_wr got %0d cycles want 1", wr_cycles - w0); end
    spi_read(7'h03, rd);
    tests++; if (rd !== 8'h40 || bidir_pu[3] !== 1'b1) begin fails++; $display("FAIL long_reg got %h pu %b want 40 1", rd, bidir_pu[3]); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] rd;
    int w0;
    w0 = wr_cycles;
    spi_write(16'h8130);
    spi_write(16'hA880);
    spi_write(16'h86C0);
    tests++; if (wr_cycles !== w0 + 3) begin fails++; $display("FAIL b2b_wr got %0d cycles want 3", wr_cycles - w0); end
    tests++; if (bidir_cs[1] !== 1'b1 || bidir_sl[1] !== 1'b1 || bidir_ie[1] !== 1'b0) begin fails++; $display("FAIL b2b_pad1 got cs %b sl %b ie %b want 1 1 0", bidir_cs[1], bidir_sl[1], bidir_ie[1]); end
    tests++; if (bidir_pd[40] !== 1'b1) begin fails++; $display("FAIL b2b_pad40 got pd %b want 1", bidir_pd[40]); end
    tests++; if (bidir_pu[6] !== 1'b1 || bidir_pd[6] !== 1'b0) begin fails++; $display("FAIL conflict got pu %b pd %b want 1 0", bidir_pu[6], bidir_pd[6]); end
    spi_read(7'h06, rd);
    tests++; if (rd !== 8'h40) begin fails++; $display("FAIL conflict_read got %h want 40", rd); end
    w0 = wr_cycles;
    spi_write(16'hFF00);
    spi_read(7'h7F, rd);
    tests++; if (rd !== 8'hB7 || wr_cycles !== w0) begin fails++; $display("FAIL id_ro got %h wr %0d want b7 0", rd, wr_cycles - w0); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] rd;
    int w0;
    w0 = wr_cycles;
    spi_frame(16'h81FF, 16, 10, rd);
    tests++; if (wr_cycles !== w0) begin fails++; $display("FAIL rstmid_wr got %0d cycles want 0", wr_cycles - w0); end
    tests++; if (bidir_pu[3] !== 1'b0 || bidir_cs[1] !== 1'b0 || bidir_ie !== {NB{1'b1}}) begin fails++; $display("FAIL rstmid_regs got pu3 %b cs1 %b ie %h", bidir_pu[3], bidir_cs[1], bidir_ie); end
    tests++; if (bidir_oe[5] !== core_oe[5] || input_pu[0] !== 1'b0) begin fails++; $display("FAIL rstmid_ovr got oe5 %b in_pu0 %b want %b 0", bidir_oe[5], input_pu[0], core_oe[5]); end
    spi_read(7'h05, rd);
    tests++; if (rd !== 8'h08) begin fails++; $display("FAIL rstmid_read got %h want 08", rd); end
  endtask

  task automatic test_lock;
    logic [7:0] rd;
    int w0;
`ifdef PAD_CFG_LOCK_EN
    w0 = wr_cycles;
    spi_write(16'hFEA5);
    tests++; if (wr_cycles !== w0 + 1) begin fails++; $display("FAIL lock_set got %0d cycles want 1", wr_cycles - w0); end
    w0 = wr_cycles;
    spi_write(16'h8240);
    tests++; if (wr_cycles !== w0 || bidir_pu[2] !== 1'b0) begin fails++; $display("FAIL lock_block got wr %0d pu2 %b want 0 0", wr_cycles - w0, bidir_pu[2]); end
    spi_read(7'h7E, rd);
    tests++; if (rd !== 8'h01) begin fails++; $display("FAIL lock_read got %h want 01", rd); end
`else
    w0 = wr_cycles;
    spi_write(16'hFEA5);
    spi_read(7'h7E, rd);
    tests++; if (rd !== 8'h00 || wr_cycles !== w0) begin fails++; $display("FAIL lock_absent got %h wr %0d want 00 0", rd, wr_cycles - w0); end
    spi_write(16'h8240);
    tests++; if (bidir_pu[2] !== 1'b1) begin fails++; $display("FAIL unlocked_wr got pu2 %b want 1", bidir_pu[2]); end
`endif
  endtask

  initial begin
    test_reset;
    test_write_override;
    test_read;
    test_input_pull;
    test_partial;
    test_back_to_back;
    test_reset_mid_frame;
    test_lock;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
